ex_stage_pipl: RTL and testbench

//  Execute stage directly downstream of the ID/EX pipeline register. Unpacks the 153-bit ID/EX bundle.

---
 rtl/pipl_pkg.sv | 57 +++++
 rtl/ex_mul_iter.sv | 62 ++++++
 rtl/ex_stage_pipl.sv | 111 +++++++++++
 tb/tb_ex_stage_pipl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipl_pkg.sv
`timescale 1ns/1ps
// Shared pipeline definitions: ALU opcodes, bundle widths and field positions
// for the ID/EX and EX/MEM registers.
package pipl_pkg;
  localparam int IDEX_W  = 153;
  localparam int EXMEM_W = 107;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1101;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  // ID/EX field positions
  localparam int ID_INSTR_HI = 152, ID_INSTR_LO = 121;
  localparam int ID_RA_HI    = 120, ID_RA_LO    = 116;
  localparam int ID_RB_HI    = 115, ID_RB_LO    = 111;
  localparam int ID_WA_HI    = 110, ID_WA_LO    = 106;
  localparam int ID_IMM_HI   = 105, ID_IMM_LO   = 74;
  localparam int ID_RDA_HI   = 73,  ID_RDA_LO   = 42;
  localparam int ID_RDB_HI   = 41,  ID_RDB_LO   = 10;
  localparam int ID_OP_HI    = 9,   ID_OP_LO    = 6;
  localparam int ID_BRNCH    = 5;
  localparam int ID_MEM_RD   = 4;
  localparam int ID_M2R      = 3;
  localparam int ID_MEM_WR   = 2;
  localparam int ID_ALU_SRC  = 1;
  localparam int ID_REG_WR   = 0;

  // EX/MEM field positions
  localparam int EX_BROFF_HI = 106, EX_BROFF_LO = 75;
  localparam int EX_ZERO     = 74;
  localparam int EX_RES_HI   = 73,  EX_RES_LO   = 42;
  localparam int EX_WDATA_HI = 41,  EX_WDATA_LO = 10;
  localparam int EX_WA_HI    = 9,   EX_WA_LO    = 5;
  localparam int EX_CTRL_HI  = 4,   EX_CTRL_LO  = 0;

  typedef struct packed {
    logic [31:0] br_off;
    logic        zero;
    logic [31:0] alu_res;
    logic [31:0] wdata;
    logic [4:0]  wa;
    logic        brnch;
    logic        mem_rd;
    logic        mem_to_rgs;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;
endpackage

// File: rtl/ex_mul_iter.sv
`timescale 1ns/1ps
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits kept.
// DONE holds the product for one cycle so the EX/MEM register can capture it.
module ex_mul_iter
  import pipl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  mul_state_e      r_state, w_nxt;
  logic [XLEN-1:0] r_a, r_b, r_acc;
  logic [CW-1:0]   r_cnt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      MUL_IDLE: if (i_start) w_nxt = MUL_BUSY;
      MUL_BUSY: if (i_abort) w_nxt = MUL_IDLE;
                else if (r_cnt == LAST) w_nxt = MUL_DONE;
      MUL_DONE: w_nxt = MUL_IDLE;
      default:  w_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= MUL_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == MUL_IDLE && i_start) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == MUL_BUSY && !i_abort) begin
        if (r_b[r_cnt]) r_acc <= r_acc + (r_a << r_cnt);
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_busy    = (r_state == MUL_BUSY);
  assign o_done    = (r_state == MUL_DONE);
  assign o_product = r_acc;
endmodule

// File: rtl/ex_stage_pipl.sv
`timescale 1ns/1ps
// Execute stage: unpacks ID/EX, computes the ALU result (MUL through ex_mul_iter)
// and registers the EX/MEM bundle; stalls upstream while a multiply is running.
module ex_stage_pipl
  import pipl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [IDEX_W-1:0]  i_idex_reg,
  input  logic               i_idex_vld,
  input  logic               i_flush,
  output logic               o_stall,
  output logic [EXMEM_W-1:0] o_exmem_reg,
  output logic               o_exmem_vld,
  output logic               o_take_brnch
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] w_rda, w_rdb, w_imm, w_a, w_b, w_alu, w_res, w_prod;
  logic [3:0]      w_op;
  logic            w_is_mul, w_start, w_load, w_mul_busy, w_mul_done, w_zero;
  logic            w_unused_idex;
  exmem_t          w_ex_nxt, r_exmem;
  logic            r_vld, r_take;

  assign w_rda = i_idex_reg[ID_RDA_HI:ID_RDA_LO];
  assign w_rdb = i_idex_reg[ID_RDB_HI:ID_RDB_LO];
  assign w_imm = i_idex_reg[ID_IMM_HI:ID_IMM_LO];
  assign w_op  = i_idex_reg[ID_OP_HI:ID_OP_LO];
  assign w_a   = w_rda;
  assign w_b   = i_idex_reg[ID_ALU_SRC] ? w_imm : w_rdb;
  assign w_unused_idex = ^i_idex_reg[ID_INSTR_HI:ID_RB_LO];

  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_AND: w_alu = w_a & w_b;
      ALU_OR:  w_alu = w_a | w_b;
      ALU_ADD: w_alu = w_a + w_b;
      ALU_XOR: w_alu = w_a ^ w_b;
      ALU_SLL: w_alu = w_a << w_b[SHW-1:0];
      ALU_SRL: w_alu = w_a >> w_b[SHW-1:0];
      ALU_SUB: w_alu = w_a - w_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_SRA: w_alu = $signed(w_a) >>> w_b[SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  // A MUL only starts from IDLE; while busy/done the held ID/EX bundle is the same MUL.
  assign w_is_mul = (w_op == ALU_MUL);
  assign w_start  = i_idex_vld & w_is_mul & ~i_flush & ~w_mul_busy & ~w_mul_done;
  assign w_load   = ~i_flush & (w_mul_done | (i_idex_vld & ~w_is_mul & ~w_mul_busy));
  assign o_stall  = i_reset_n & ~i_flush & (w_start | w_mul_busy);
  assign w_res    = w_mul_done ? w_prod : w_alu;
  assign w_zero   = (w_res == '0);

  ex_mul_iter #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_start   (w_start),
    .i_abort   (i_flush),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  always_comb begin
    w_ex_nxt            = '0;
    w_ex_nxt.br_off     = w_imm;
    w_ex_nxt.zero       = w_zero;
    w_ex_nxt.alu_res    = w_res;
    w_ex_nxt.wdata      = w_rdb;
    w_ex_nxt.wa         = i_idex_reg[ID_WA_HI:ID_WA_LO];
    w_ex_nxt.brnch      = i_idex_reg[ID_BRNCH];
    w_ex_nxt.mem_rd     = i_idex_reg[ID_MEM_RD];
    w_ex_nxt.mem_to_rgs = i_idex_reg[ID_M2R];
    w_ex_nxt.mem_wr     = i_idex_reg[ID_MEM_WR];
    w_ex_nxt.reg_wr     = i_idex_reg[ID_REG_WR];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_exmem <= '0;
      r_vld   <= 1'b0;
      r_take  <= 1'b0;
    end else if (w_load) begin
      r_exmem <= w_ex_nxt;
      r_vld   <= 1'b1;
      r_take  <= w_ex_nxt.brnch & w_ex_nxt.zero;
    end else begin
      // Bubble: data fields keep stale values, control bits must not act downstream.
      r_vld              <= 1'b0;
      r_take             <= 1'b0;
      r_exmem.brnch      <= 1'b0;
      r_exmem.mem_rd     <= 1'b0;
      r_exmem.mem_to_rgs <= 1'b0;
      r_exmem.mem_wr     <= 1'b0;
      r_exmem.reg_wr     <= 1'b0;
    end
  end

  assign o_exmem_reg  = r_exmem;
  assign o_exmem_vld  = r_vld;
  assign o_take_brnch = r_take;
endmodule

// File: tb/tb_ex_stage_pipl.sv
`timescale 1ns/1ps
// Scoreboard bench for ex_stage_pipl: driver pushes expected EX/MEM bundles,
// a negedge monitor pops and compares whenever exmem_vld is high.
module tb_ex_stage_pipl;
  localparam int MULC = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [152:0] idex_reg;
  logic         idex_vld, flush;
  logic         stall;
  logic [106:0] exmem_reg;
  logic         exmem_vld, take_brnch;

  int n_chk = 0;
  int n_fail = 0;
  logic [106:0] q_ex[$];
  logic         q_tb[$];

  always #5 clk = ~clk;

  ex_stage_pipl #(.XLEN(32), .MUL_CYCLES(MULC)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_idex_reg   (idex_reg),
    .i_idex_vld   (idex_vld),
    .i_flush      (flush),
    .o_stall      (stall),
    .o_exmem_reg  (exmem_reg),
    .o_exmem_vld  (exmem_vld),
    .o_take_brnch (take_brnch)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference ALU from the opcode table, plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a << s;
      4'd5:  return a >> s;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [152:0] mk(input logic [3:0] op, input logic [31:0] rda, input logic [31:0] rdb,
                                      input logic [31:0] imm, input logic src, input logic br);
    logic [31:0] instr;
    logic [4:0]  ra, rb, wa;
    logic [2:0]  mc;
    instr = $urandom; ra = 5'($urandom); rb = 5'($urandom); wa = 5'($urandom); mc = 3'($urandom);
    return {instr, ra, rb, wa, imm, rda, rdb, op, br, mc, src, 1'b1};
  endfunction

  // Drive one bundle at a negedge, hold it while stall is high, then score it.
  task automatic issue(input logic [152:0] bnd, input logic fl, output int n_edge, output int n_stall);
    logic s, ok;
    logic [31:0] a, b, imm, rdb, res;
    logic z;
    n_edge = 0; n_stall = 0; ok = 1'b1;
    @(negedge clk);
    idex_reg = bnd; idex_vld = 1'b1; flush = fl;
    forever begin
      #1 s = stall;
      @(posedge clk);
      n_edge++;
      if (!s) break;
      n_stall++;
      if (n_edge > 200) begin
        n_chk++; n_fail++; ok = 1'b0;
        $display("FAIL issue_timeout: stall still high after %0d edges, expected release", n_edge);
        break;
      end
      @(negedge clk);
    end
    if (!fl && ok) begin
      a   = bnd[73:42];
      rdb = bnd[41:10];
      imm = bnd[105:74];
      b   = bnd[1] ? imm : rdb;
      res = ref_alu(bnd[9:6], a, b);
      z   = (res == 32'd0);
      q_ex.push_back({imm, z, res, rdb, bnd[110:106], bnd[5], bnd[4], bnd[3], bnd[2], bnd[0]});
      q_tb.push_back(bnd[5] & z);
    end
    #1 idex_vld = 1'b0; flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exmem_vld) begin
        if (q_ex.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_vld: exmem_vld=1 exmem=%0h, expected no output", exmem_reg);
        end else begin
          chk("exmem_reg", 128'(exmem_reg), 128'(q_ex.pop_front()));
          chk("take_brnch", 128'(take_brnch), 128'(q_tb.pop_front()));
        end
      end else begin
        chk("bubble_take", 128'(take_brnch), 128'd0);
        chk("bubble_ctrl", 128'(exmem_reg[4:0]), 128'd0);
      end
    end
  end

  initial begin
    int ne, ns, bad;
    logic [3:0] ops[12];
    logic [3:0] op;
    logic [31:0] ra, rb;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd13, 4'd8, 4'd9, 4'd15};
    rst_n = 1'b0; idex_reg = '0; idex_vld = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 128'(exmem_vld), 128'd0);
    chk("rst_reg", 128'(exmem_reg), 128'd0);
    chk("rst_take", 128'(take_brnch), 128'd0);
    chk("rst_stall", 128'(stall), 128'd0);
    #2 rst_n = 1'b1;

    issue(mk(4'd2, 32'd5, 32'd7, 32'h1234, 1'b0, 1'b0), 1'b0, ne, ns);
    @(negedge clk);
    chk("add_res", 128'(exmem_reg[73:42]), 128'd12);
    chk("add_zero", 128'(exmem_reg[74]), 128'd0);
    chk("add_vld", 128'(exmem_vld), 128'd1);
    chk("add_lat", 128'(ne), 128'd1);

    issue(mk(4'd6, 32'd9, 32'd9, 32'h40, 1'b0, 1'b1), 1'b0, ne, ns);
    @(negedge clk);
    chk("sub_res", 128'(exmem_reg[73:42]), 128'd0);
    chk("sub_zero", 128'(exmem_reg[74]), 128'd1);
    chk("sub_take", 128'(take_brnch), 128'd1);
    chk("sub_broff", 128'(exmem_reg[106:75]), 128'h40);

    issue(mk(4'd2, 32'hFFFF_FFFF, 32'd77, 32'd1, 1'b1, 1'b0), 1'b0, ne, ns);
    @(negedge clk);
    chk("wrap_res", 128'(exmem_reg[73:42]), 128'd0);
    chk("wrap_zero", 128'(exmem_reg[74]), 128'd1);
    chk("wrap_wdata", 128'(exmem_reg[41:10]), 128'd77);

    issue(mk(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0), 1'b0, ne, ns);
    @(negedge clk);
    chk("slt_res", 128'(exmem_reg[73:42]), 128'd1);

    issue(mk(4'd8, 32'd3, 32'h10001, 32'd0, 1'b0, 1'b0), 1'b0, ne, ns);
    chk("mul_latency", 128'(ne), 128'(MULC + 2));
    chk("mul_stall_cycles", 128'(ns), 128'(MULC + 1));
    @(negedge clk);
    chk("mul_res", 128'(exmem_reg[73:42]), 128'h30003);
    chk("mul_vld", 128'(exmem_vld), 128'd1);
    @(negedge clk);
    chk("mul_once", 128'(exmem_vld), 128'd0);

    // Flush while the multiplier is iterating
    @(negedge clk);
    idex_reg = mk(4'd8, 32'd11, 32'd13, 32'd0, 1'b0, 1'b0); idex_vld = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_stall_drop", 128'(stall), 128'd0);
    @(posedge clk);
    #1 flush = 1'b0; idex_vld = 1'b0;
    @(negedge clk);
    chk("flush_stall_after", 128'(stall), 128'd0);
    chk("flush_vld_after", 128'(exmem_vld), 128'd0);
    bad = 0;
    repeat (MULC + 5) begin
      @(negedge clk);
      if (exmem_vld) bad++;
    end
    chk("flush_no_result", 128'(bad), 128'd0);

    // Async reset between edges in the middle of a multiply
    @(negedge clk);
    idex_reg = mk(4'd8, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0); idex_vld = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_stall", 128'(stall), 128'd0);
    chk("mrst_vld", 128'(exmem_vld), 128'd0);
    chk("mrst_reg", 128'(exmem_reg), 128'd0);
    chk("mrst_take", 128'(take_brnch), 128'd0);
    idex_vld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(mk(4'd2, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0), 1'b0, ne, ns);
    @(negedge clk);
    chk("post_rst_add", 128'(exmem_reg[73:42]), 128'd123);

    // flush together with a valid instruction registers nothing
    issue(mk(4'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0), 1'b1, ne, ns);
    @(negedge clk);
    chk("flush_vld_same", 128'(exmem_vld), 128'd0);

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(11)];
      ra = $urandom;
      rb = ($urandom_range(3) == 0) ? ra : 32'($urandom);
      if (op == 4'd4 || op == 4'd5 || op == 4'd13) rb = $urandom_range(31);
      issue(mk(op, ra, rb, ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom),
               1'($urandom), 1'($urandom)), ($urandom_range(9) == 0), ne, ns);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(q_ex.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
